jpeg_quant_zigzag: RTL and testbench
====================================

// Module: jpeg_quant_zigzag
// PURPOSE
//  Downstream stage of the 2D DCT. Captures one 8x8 block of 10-bit signed
//  DCT coefficients (row-major), quantizes each coefficient against a
//  host-loaded reciprocal table and streams the results out serially in
//  JPEG zigzag order (valid/ready) toward the run-length/Huffman encoder.
// PARAMETERS
//  COEF_W   10  coefficient width in and out (two's complement)
//  RECIP_W  17  reciprocal width; entry = round(2^16/Q), Q=1..255 (Q=1 -> 65536)
// PORTS
//  clock      in   1        clock
//  reset_n    in   1        asynchronous, active-low reset
//  in_valid   in   1        block present on coef_in (1-cycle strobe from DCT done)
//  in_ready   out  1        1 = IDLE, block will be captured
//  coef_in    in   [9:0] x64  unpacked array [0:63], row-major, signed
//  qt_we      in   1        quant table write strobe
//  qt_addr    in   6        table index, natural row-major order
//  qt_data    in   RECIP_W  reciprocal value
//  out_valid  out  1        out_data valid
//  out_ready  in   1        downstream accepts when out_valid&out_ready
//  out_data   out  COEF_W   quantized coefficient, signed
//  out_idx    out  6        zigzag position 0..63 of out_data
//  out_last   out  1        1 with out_idx==63
//  drop_err   out  1        sticky: block or table write rejected while busy
// BEHAVIOUR
//  - Reset (async): FSM=IDLE, in_ready=1, out_valid/out_last/drop_err=0,
//    out_data/out_idx=0, capture buffer cleared, all table entries=65536.
//  - FSM IDLE: in_valid -> latch all 64 coef_in into buffer, k=0, go RUN.
//  - FSM RUN: pipeline stage1 reads buf[ZZ[k]] and qt[ZZ[k]] into operand
//    regs; stage2 computes result into out regs. Pipeline advances only when
//    !out_valid || out_ready; otherwise all stages hold (no loss/duplication).
//  - Latency: capture at cycle N, first out_valid at N+2; with out_ready held
//    high, one beat per cycle, out_last at N+65; FSM back to IDLE (in_ready=1)
//    the cycle after the out_last beat is accepted.
//  - Arithmetic: m=|c| (17-bit product domain, |-512|=512 legal);
//    q=(m*recip + 2^15)>>16 (round half away from zero); out = sign? -q : q;
//    result clipped to [-512,511] (only reachable via malformed recip).
//  - ZZ table: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,
//    34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,
//    51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
//  - in_valid while not IDLE: ignored, drop_err<=1. qt_we while not IDLE:
//    ignored, drop_err<=1. qt_we in IDLE: write applies next cycle.
//  - in_valid and qt_we same IDLE cycle: both take effect; captured block
//    uses the new entry.
//  - drop_err clears only on reset.
//  - Reset mid-RUN: block abandoned, no further beats, table back to default.
// TESTING
//  1 Reset: out_valid=0, in_ready=1, drop_err=0; 64 default beats of
//    coef_in[i]=i give out_data 0,1,8,16,9,2,... (identity quantization).
//  2 Identity table, ramp block, out_ready=1: beat at N+2 = 0, beat 3 = 8,
//    beat 64 = 63 with out_idx=63, out_last=1; in_ready=1 at N+66.
//  3 Rounding: all qt=4096 (Q=16), coef[0]=100,[1]=-100,[8]=8,[16]=-8,[9]=7
//    -> first five beats 6,-6,1,-1,0.
//  4 Extreme: coef[0]=-512, coef[1]=511, Q=1 -> -512, 511; Q=255
//    (recip=257) -> -2, 2.
//  5 Backpressure: random out_ready 50%: exactly 64 beats, order/values
//    match scoreboard, out_data stable while out_valid&!out_ready.
//  6 Busy: in_valid and qt_we at beat 10 -> ignored, drop_err=1, stream
//    unchanged; reset_n low at beat 20 -> out_valid=0 immediately, next block
//    quantizes with default table.

Source files
------------

// File: rtl/jpeg_quant_zigzag.sv
// jpeg_quant_zigzag
//   Stage after the 2D DCT. Captures one 8x8 block of signed coefficients
//   (row-major), quantizes each one by multiplying with a host-loaded
//   reciprocal (round(2^16/Q)), and streams the results out in JPEG zigzag
//   order toward the run-length/Huffman encoder.
//
// Ports
//   clock, reset_n      clock; asynchronous active-low reset
//   in_valid/in_ready   block strobe; in_ready=1 only while IDLE
//   coef_in[0:63]       block coefficients, row-major, signed COEF_W
//   qt_we/addr/data     reciprocal table write (row-major index), IDLE only
//   out_valid/ready     output handshake
//   out_data            quantized coefficient, signed COEF_W
//   out_idx, out_last   zigzag position of out_data; out_last with idx 63
//   drop_err            sticky: block or table write arrived while busy
//
// Handshake: a beat transfers on every rising edge where out_valid and
// out_ready are both 1. Once out_valid is raised, out_data/out_idx/out_last
// hold steady until that transfer. The whole two-stage pipeline advances only
// when the output register is empty or being drained (!out_valid || out_ready).
module jpeg_quant_zigzag #(
    parameter int COEF_W  = 10,
    parameter int RECIP_W = 17
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [COEF_W-1:0] coef_in [0:63],
    input  logic                     qt_we,
    input  logic [5:0]               qt_addr,
    input  logic [RECIP_W-1:0]       qt_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [COEF_W-1:0] out_data,
    output logic [5:0]               out_idx,
    output logic                     out_last,
    output logic                     drop_err
);

    localparam logic [5:0] ZZ [0:63] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    localparam logic [RECIP_W-1:0] RECIP_ONE = RECIP_W'(65536);  // Q = 1
    localparam int PROD_W = COEF_W + RECIP_W;
    localparam int Q_W    = PROD_W - 16;
    localparam logic signed [Q_W:0] MAX_V = (Q_W+1)'(2**(COEF_W-1) - 1);
    localparam logic signed [Q_W:0] MIN_V = -(Q_W+1)'(2**(COEF_W-1));

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    state_t state;

    logic signed [COEF_W-1:0]  coef_buf [0:63];
    logic [RECIP_W-1:0]        qt [0:63];
    logic [5:0]                k;
    logic                      issuing;     // still reading coefficients out of the buffer
    logic                      s1_valid;
    logic signed [COEF_W-1:0]  s1_coef;
    logic [RECIP_W-1:0]        s1_recip;
    logic [5:0]                s1_idx;
    logic                      advance;

    logic [COEF_W-1:0]         mag;
    logic [PROD_W-1:0]         prod;
    logic [Q_W-1:0]            q;
    logic signed [Q_W:0]       sq;
    logic signed [COEF_W-1:0]  res;

    assign advance = !out_valid || out_ready;

    // Magnitude is taken as unsigned so that |-512| = 512 is representable.
    // Adding 2^15 before the shift rounds half away from zero on the magnitude.
    always_comb begin
        mag  = s1_coef[COEF_W-1] ? COEF_W'(-s1_coef) : COEF_W'(s1_coef);
        prod = PROD_W'(mag) * PROD_W'(s1_recip) + PROD_W'(32768);
        q    = Q_W'(prod >> 16);
        sq   = s1_coef[COEF_W-1] ? -$signed({1'b0, q}) : $signed({1'b0, q});
        if (sq > MAX_V)
            res = MAX_V[COEF_W-1:0];
        else if (sq < MIN_V)
            res = MIN_V[COEF_W-1:0];
        else
            res = $signed(sq[COEF_W-1:0]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            drop_err  <= 1'b0;
            k         <= '0;
            issuing   <= 1'b0;
            s1_valid  <= 1'b0;
            s1_coef   <= '0;
            s1_recip  <= '0;
            s1_idx    <= '0;
            for (int i = 0; i < 64; i++) begin
                coef_buf[i] <= '0;
                qt[i]       <= RECIP_ONE;
            end
        end else begin
            case (state)
                IDLE: begin
                    // A table write in the capture cycle lands before the
                    // first table read one cycle later, so the block sees it.
                    if (qt_we)
                        qt[qt_addr] <= qt_data;
                    if (in_valid) begin
                        for (int i = 0; i < 64; i++)
                            coef_buf[i] <= coef_in[i];
                        k        <= '0;
                        issuing  <= 1'b1;
                        state    <= RUN;
                        in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    if (in_valid || qt_we)
                        drop_err <= 1'b1;
                    if (advance) begin
                        s1_valid <= issuing;
                        if (issuing) begin
                            s1_coef  <= coef_buf[ZZ[k]];
                            s1_recip <= qt[ZZ[k]];
                            s1_idx   <= k;
                            k        <= k + 6'd1;
                            if (k == 6'd63)
                                issuing <= 1'b0;
                        end
                        out_valid <= s1_valid;
                        if (s1_valid) begin
                            out_data <= res;
                            out_idx  <= s1_idx;
                            out_last <= (s1_idx == 6'd63);
                        end else begin
                            out_last <= 1'b0;
                        end
                    end
                    if (out_valid && out_ready && out_last) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_quant_zigzag.sv
// Self-checking bench for jpeg_quant_zigzag: directed blocks, a reference
// model of the quantizer and zigzag walk, and one compare process that checks
// every accepted output beat and every held (stalled) beat.
module tb_jpeg_quant_zigzag;

    localparam int CW = 10;
    localparam int RW = 17;

    // ---------------- clock / reset / DUT ----------------
    logic                 clock = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 qt_we = 1'b0;
    logic                 out_ready = 1'b1;
    logic [5:0]           qt_addr = '0;
    logic [RW-1:0]        qt_data = '0;
    logic signed [CW-1:0] coef_in [0:63];
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_last;
    logic                 drop_err;
    logic signed [CW-1:0] out_data;
    logic [5:0]           out_idx;

    jpeg_quant_zigzag #(.COEF_W(CW), .RECIP_W(RW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .coef_in   (coef_in),
        .qt_we     (qt_we),
        .qt_addr   (qt_addr),
        .qt_data   (qt_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .drop_err  (drop_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- model state ----------------
    int                   n_cmp = 0;
    int                   n_fail = 0;
    int                   zz [64];
    int                   tbl [64];
    logic [16:0]          exp_q [$];
    int                   got_q [$];
    int                   beat_cnt = 0;
    int                   first_cyc = -1;
    int                   last_cyc = -1;
    int                   cap_cyc = 0;
    int                   rdy_cyc = -1;
    logic signed [CW-1:0] blk [0:63];
    bit                   bp_mode = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Quantizer from its arithmetic definition.
    function automatic int quant(input int c, input int recip);
        int m, q, r;
        m = (c < 0) ? -c : c;
        q = (m * recip + 32768) / 65536;
        r = (c < 0) ? -q : q;
        if (r > 511) r = 511;
        if (r < -512) r = -512;
        return r;
    endfunction

    function automatic int recip_of(input int qv);
        return (131072 / qv + 1) / 2;
    endfunction

    function automatic int got_at(input int i);
        return (got_q.size() > i) ? got_q[i] : -9999;
    endfunction

    // Zigzag walk over anti-diagonals: even diagonals go up-right, odd go down-left.
    task automatic build_zigzag();
        int n = 0;
        for (int s = 0; s < 15; s++) begin
            int lo, hi;
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zz[n] = r * 8 + (s - r); n++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zz[n] = r * 8 + (s - r); n++; end
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 64; i++) tbl[i] = 65536;
    endtask

    // ---------------- driver tasks ----------------
    task automatic qt_write(input int a, input int d);
        @(posedge clock); #1;
        qt_we = 1'b1; qt_addr = 6'(a); qt_data = RW'(d);
        @(posedge clock); #1;
        qt_we = 1'b0;
        tbl[a] = d;
    endtask

    task automatic send_block(input bit wr, input int a, input int d);
        @(posedge clock); #1;
        got_q.delete(); beat_cnt = 0; first_cyc = -1; last_cyc = -1;
        for (int i = 0; i < 64; i++) coef_in[i] = blk[i];
        in_valid = 1'b1;
        if (wr) begin
            qt_we = 1'b1; qt_addr = 6'(a); qt_data = RW'(d);
            tbl[a] = d;
        end
        @(posedge clock); #1;
        in_valid = 1'b0; qt_we = 1'b0;
        cap_cyc = cyc;
        for (int kk = 0; kk < 64; kk++)
            exp_q.push_back({kk == 63, 6'(kk), 10'(quant(int'(blk[zz[kk]]), tbl[zz[kk]]))});
    endtask

    task automatic wait_done(input int budget);
        int i;
        rdy_cyc = -1;
        for (i = 0; i < budget; i++) begin
            @(negedge clock);
            if (in_ready && rdy_cyc < 0) rdy_cyc = cyc;
            if (in_ready && exp_q.size() == 0) break;
        end
        check("block_done_in_budget", int'(i < budget), 1);
    endtask

    task automatic wait_beats(input int n);
        int i;
        for (i = 0; i < 300 && beat_cnt < n; i++) begin
            @(posedge clock); #1;
        end
        check("beats_reached", int'(beat_cnt >= n), 1);
    endtask

    // out_ready pattern: always 1, or a coin flip per cycle.
    initial begin
        forever begin
            @(posedge clock); #1;
            out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- scoreboard / compare process ----------------
    logic        held_v = 1'b0;
    logic [16:0] held;
    logic [16:0] cur_beat;
    logic [16:0] e_beat;

    always @(negedge clock) begin
        if (!reset_n) begin
            held_v = 1'b0;
        end else begin
            cur_beat = {out_last, out_idx, out_data};
            if (held_v)
                check("hold_stable", int'({out_valid, cur_beat}), int'({1'b1, held}));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    e_beat = exp_q.pop_front();
                    check("beat_data", int'(out_data), int'($signed(e_beat[9:0])));
                    check("beat_idx", int'(out_idx), int'(e_beat[15:10]));
                    check("beat_last", int'(out_last), int'(e_beat[16]));
                end
                if (beat_cnt == 0) first_cyc = cyc;
                if (out_last) last_cyc = cyc;
                got_q.push_back(int'(out_data));
                beat_cnt++;
            end
            held_v = out_valid && !out_ready;
            held   = cur_beat;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        build_zigzag();
        model_reset();
        for (int i = 0; i < 64; i++) coef_in[i] = '0;

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_drop_err", int'(drop_err), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_idx", int'(out_idx), 0);
        check("rst_out_data", int'(out_data), 0);
        reset_n = 1'b1;

        // Identity table, ramp block: zigzag order and latency
        for (int i = 0; i < 64; i++) blk[i] = CW'(i);
        send_block(1'b0, 0, 0);
        wait_done(200);
        check("first_beat_cycle", first_cyc, cap_cyc + 2);
        check("last_beat_cycle", last_cyc, cap_cyc + 65);
        check("in_ready_back_cycle", rdy_cyc, cap_cyc + 66);
        check("ramp_count", got_q.size(), 64);
        check("ramp_b0", got_at(0), 0);
        check("ramp_b1", got_at(1), 1);
        check("ramp_b2", got_at(2), 8);
        check("ramp_b3", got_at(3), 16);
        check("ramp_b4", got_at(4), 9);
        check("ramp_b5", got_at(5), 2);
        check("ramp_b63", got_at(63), 63);

        // Rounding with Q=16 everywhere
        for (int a = 0; a < 64; a++) qt_write(a, 4096);
        for (int i = 0; i < 64; i++) blk[i] = '0;
        blk[0] = 10'sd100; blk[1] = -10'sd100; blk[8] = 10'sd8; blk[16] = -10'sd8; blk[9] = 10'sd7;
        send_block(1'b0, 0, 0);
        wait_done(200);
        check("round_b0", got_at(0), 6);
        check("round_b1", got_at(1), -6);
        check("round_b2", got_at(2), 1);
        check("round_b3", got_at(3), -1);
        check("round_b4", got_at(4), 0);

        // Extremes, Q=1
        qt_write(0, 65536);
        qt_write(1, 65536);
        for (int i = 0; i < 64; i++) blk[i] = '0;
        blk[0] = -10'sd512; blk[1] = 10'sd511;
        send_block(1'b0, 0, 0);
        wait_done(200);
        check("q1_neg", got_at(0), -512);
        check("q1_pos", got_at(1), 511);

        // Extremes, Q=255; entry 1 written in the same cycle as the capture
        qt_write(0, 257);
        send_block(1'b1, 1, 257);
        wait_done(200);
        check("q255_neg", got_at(0), -2);
        check("q255_pos", got_at(1), 2);

        // Random table and block under random backpressure
        for (int a = 0; a < 64; a++) qt_write(a, recip_of($urandom_range(1, 255)));
        for (int i = 0; i < 64; i++) blk[i] = CW'($urandom_range(0, 1023));
        blk[5] = -10'sd512; blk[40] = 10'sd511;
        bp_mode = 1'b1;
        send_block(1'b0, 0, 0);
        wait_done(1000);
        bp_mode = 1'b0;
        check("bp_beat_count", beat_cnt, 64);
        check("bp_drop_err_clear", int'(drop_err), 0);

        // Busy: block and table write mid-stream are dropped
        qt_write(63, 65536);
        for (int i = 0; i < 64; i++) blk[i] = CW'(i);
        send_block(1'b0, 0, 0);
        wait_beats(10);
        for (int i = 0; i < 64; i++) coef_in[i] = 10'sd100;
        in_valid = 1'b1; qt_we = 1'b1; qt_addr = 6'd63; qt_data = RW'(1);
        @(posedge clock); #1;
        in_valid = 1'b0; qt_we = 1'b0;
        check("busy_drop_err", int'(drop_err), 1);
        wait_done(300);
        check("busy_beat_count", beat_cnt, 64);
        check("busy_last_value", got_at(63), 63);
        check("busy_drop_err_sticky", int'(drop_err), 1);

        // Reset mid-stream
        send_block(1'b0, 0, 0);
        wait_beats(20);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_drop_err", int'(drop_err), 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("midrst_no_beats", int'(out_valid), 0);

        // Next block uses the default (identity) table
        send_block(1'b0, 0, 0);
        wait_done(200);
        check("post_rst_count", beat_cnt, 64);
        check("post_rst_b2", got_at(2), 8);
        check("post_rst_b10", got_at(10), 32);
        check("post_rst_b63", got_at(63), 63);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
